// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings for the memory port arbiter.
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_I_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Fetches are always full-word reads on the shared bus.
    localparam logic [2:0] C_FETCH_MODE = 3'b010;

    function automatic logic is_busy(input arb_state_t s);
        return (s == ST_D_BUSY) || (s == ST_I_BUSY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// bus_watchdog: counts cycles while enabled; expired flags the TIMEOUT-th cycle.
`default_nettype none

module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data ports of the core,
// one transaction at a time, with D-burst fairness, fetch kill and a bus watchdog.
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adrs,
    input  logic              flush_F,
    output logic [DATA_W-1:0] i_rd,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_mode,
    input  logic [ADDR_W-1:0] d_adrs,
    input  logic [DATA_W-1:0] d_wd,
    output logic [DATA_W-1:0] d_rd,
    output logic              d_valid,
    output logic              stall_F,
    output logic              stall_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [2:0]        bus_mode,
    output logic [ADDR_W-1:0] bus_adrs,
    output logic [DATA_W-1:0] bus_wd,
    input  logic [DATA_W-1:0] bus_rd,
    input  logic              bus_ack,
    output logic              bus_err
);

    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] C_BURST_MAX = BW'(MAX_D_BURST);

    arb_state_t        state_q;
    arb_owner_t        owner_w;
    logic [BW-1:0]     burst_q;
    logic              kill_q;
    logic              i_valid_q, d_valid_q;
    logic [DATA_W-1:0] i_rd_q, d_rd_q;
    logic              bus_req_q, bus_we_q, bus_err_q;
    logic [2:0]        bus_mode_q;
    logic [ADDR_W-1:0] bus_adrs_q;
    logic [DATA_W-1:0] bus_wd_q;

    logic              grant_dport_w, grant_iport_w;
    logic              busy_w, expired_w, done_w;
    logic [DATA_W-1:0] ret_data_w;

    // D wins unless I has waited through a full burst of D grants.
    assign grant_dport_w = d_req && !(i_req && (burst_q == C_BURST_MAX));
    assign grant_iport_w = i_req && !flush_F && !grant_dport_w;

    assign busy_w     = is_busy(state_q);
    assign owner_w    = (state_q == ST_D_BUSY) ? OWN_D : OWN_I;
    assign done_w     = busy_w && (bus_ack || expired_w);
    assign ret_data_w = bus_ack ? bus_rd : '0;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy_w),
        .enable  (busy_w),
        .expired (expired_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            kill_q     <= 1'b0;
            i_valid_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            i_rd_q     <= '0;
            d_rd_q     <= '0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_mode_q <= '0;
            bus_adrs_q <= '0;
            bus_wd_q   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_dport_w) begin
                        state_q    <= ST_D_BUSY;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= d_we;
                        bus_mode_q <= d_mode;
                        bus_adrs_q <= d_adrs;
                        bus_wd_q   <= d_wd;
                        if (!i_req)
                            burst_q <= '0;
                        else if (burst_q != C_BURST_MAX)
                            burst_q <= burst_q + 1'b1;
                    end else if (grant_iport_w) begin
                        state_q    <= ST_I_BUSY;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_mode_q <= C_FETCH_MODE;
                        bus_adrs_q <= i_adrs;
                        bus_wd_q   <= '0;
                        burst_q    <= '0;
                        kill_q     <= 1'b0;
                    end else if (!i_req) begin
                        burst_q <= '0;
                    end
                end
                ST_D_BUSY, ST_I_BUSY: begin
                    if (flush_F && (owner_w == OWN_I))
                        kill_q <= 1'b1;
                    if (done_w) begin
                        state_q   <= ST_RESP;
                        bus_req_q <= 1'b0;
                        if (!bus_ack)
                            bus_err_q <= 1'b1;
                        if (owner_w == OWN_D) begin
                            d_valid_q <= 1'b1;
                            if (!bus_we_q)
                                d_rd_q <= ret_data_w;
                        end else if (!(kill_q || flush_F)) begin
                            i_valid_q <= 1'b1;
                            i_rd_q    <= ret_data_w;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the response cycle still has to swallow the fetch pulse.
    assign i_valid  = i_valid_q && !flush_F;
    assign d_valid  = d_valid_q;
    assign i_rd     = i_rd_q;
    assign d_rd     = d_rd_q;
    assign stall_F  = i_req && !i_valid;
    assign stall_M  = d_req && !d_valid;
    assign bus_req  = bus_req_q;
    assign bus_we   = bus_we_q;
    assign bus_mode = bus_mode_q;
    assign bus_adrs = bus_adrs_q;
    assign bus_wd   = bus_wd_q;
    assign bus_err  = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MAX_D_BURST = 4;
    localparam int TIMEOUT     = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, flush_F, d_req, d_we;
    logic [ADDR_W-1:0] i_adrs, d_adrs;
    logic [2:0]        d_mode;
    logic [DATA_W-1:0] d_wd;
    logic [DATA_W-1:0] i_rd, d_rd, bus_wd, bus_rd;
    logic              i_valid, d_valid, stall_F, stall_M;
    logic              bus_req, bus_we, bus_ack, bus_err;
    logic [2:0]        bus_mode;
    logic [ADDR_W-1:0] bus_adrs;

    logic              manual_ack, auto_ack;
    logic [DATA_W-1:0] bus_rd_drv;

    int n_checks = 0;
    int n_fail   = 0;

    int   ng, hi;
    int   grant_is_d [6];
    int   exp_is_d   [6] = '{1, 1, 1, 1, 0, 1};
    logic seen, err_seen, any_valid;
    logic [DATA_W-1:0] rd_seen;

    assign bus_ack = manual_ack | (auto_ack & bus_req);
    assign bus_rd  = bus_rd_drv;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_D_BURST (MAX_D_BURST),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_adrs   (i_adrs),
        .flush_F  (flush_F),
        .i_rd     (i_rd),
        .i_valid  (i_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_mode   (d_mode),
        .d_adrs   (d_adrs),
        .d_wd     (d_wd),
        .d_rd     (d_rd),
        .d_valid  (d_valid),
        .stall_F  (stall_F),
        .stall_M  (stall_M),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_mode (bus_mode),
        .bus_adrs (bus_adrs),
        .bus_wd   (bus_wd),
        .bus_rd   (bus_rd),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL tb_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; i_req = 0; flush_F = 0; d_req = 0; d_we = 0;
        i_adrs = '0; d_adrs = '0; d_mode = '0; d_wd = '0;
        manual_ack = 0; auto_ack = 0; bus_rd_drv = '0;
        repeat (2) tick();
        mid();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_valids", {i_valid, d_valid}, 0);
        chk("rst_rd", {i_rd, d_rd}, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_bus_adrs_mode", {bus_adrs, bus_mode, bus_we}, 0);
        chk("rst_stalls", {stall_F, stall_M}, 0);
        tick(); reset = 1'b0;
        tick();

        // Lone fetch, ack in the first bus cycle
        i_req = 1; i_adrs = 32'h10;
        mid();
        chk("fetch_n_stall", {stall_F, bus_req}, 2'b10);
        tick(); manual_ack = 1; bus_rd_drv = 32'h00500093;
        mid();
        chk("fetch_n1_bus", {bus_req, bus_we, stall_F}, 3'b101);
        chk("fetch_n1_adrs", bus_adrs, 32'h10);
        tick(); manual_ack = 0;
        mid();
        chk("fetch_n2_valid", {i_valid, bus_req, stall_F}, 3'b100);
        chk("fetch_n2_rd", i_rd, 32'h00500093);
        tick(); i_req = 0;
        mid();
        chk("fetch_n3_novalid", i_valid, 0);

        // Contention with continuous requests: expect D,D,D,D,I,D
        tick();
        auto_ack = 1; bus_rd_drv = 32'h12345678;
        i_adrs = 32'h100; d_adrs = 32'h200; d_we = 0; d_mode = 3'b010;
        i_req = 1; d_req = 1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            mid();
            if (bus_req) begin
                grant_is_d[ng] = (bus_adrs == 32'h200) ? 1 : 0;
                ng++;
            end
            if (ng < 6) tick();
        end
        chk("cont_grant_count", ng, 6);
        for (int g = 0; g < 6; g++)
            chk($sformatf("cont_grant%0d_is_d", g), grant_is_d[g], exp_is_d[g]);
        tick(); i_req = 0; d_req = 0; auto_ack = 0;
        mid();
        chk("cont_last_dvalid", d_valid, 1);
        chk("cont_last_drd", d_rd, 32'h12345678);
        tick(); tick();

        // Store with ack in the third bus cycle
        d_req = 1; d_we = 1; d_adrs = 32'h40; d_wd = 32'hDEADBEEF; d_mode = 3'b010;
        mid();
        chk("st_stall_m", stall_M, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin manual_ack = 1; bus_rd_drv = 32'hFFFFFFFF; end
            mid();
            chk($sformatf("st_ctl_c%0d", c), {bus_req, bus_we, bus_mode, d_valid}, 6'b110100);
            chk($sformatf("st_adrs_wd_c%0d", c), {bus_adrs, bus_wd}, {32'h40, 32'hDEADBEEF});
        end
        tick(); manual_ack = 0;
        mid();
        chk("st_dvalid", {d_valid, bus_req, stall_M}, 3'b100);
        chk("st_drd_kept", d_rd, 32'h12345678);
        tick(); d_req = 0; d_we = 0;
        mid();
        chk("st_dvalid_pulse", d_valid, 0);

        // Flush during I_BUSY kills the fetch result
        tick(); i_req = 1; i_adrs = 32'h20;
        tick(); flush_F = 1;
        mid();
        chk("fl_busy_req", bus_req, 1);
        tick(); flush_F = 0; i_req = 0; manual_ack = 1; bus_rd_drv = 32'h00000BAD;
        mid();
        chk("fl_no_early_valid", i_valid, 0);
        tick(); manual_ack = 0;
        mid();
        chk("fl_no_valid", {i_valid, bus_req}, 2'b00);
        chk("fl_ird_kept", i_rd, 32'h12345678);
        tick(); i_req = 1; i_adrs = 32'h30;
        tick(); manual_ack = 1; bus_rd_drv = 32'h00A00113;
        mid();
        chk("fl_next_adrs", {bus_req, bus_adrs}, {1'b1, 32'h30});
        tick(); manual_ack = 0;
        mid();
        chk("fl_next_valid", i_valid, 1);
        chk("fl_next_rd", i_rd, 32'h00A00113);
        tick(); i_req = 0;

        // Ack while idle is ignored
        tick(); manual_ack = 1;
        tick(); manual_ack = 0;
        mid();
        chk("idle_ack_ignored", {bus_req, i_valid, d_valid}, 0);

        // Timeout on a load with no ack
        tick(); d_req = 1; d_we = 0; d_adrs = 32'h80;
        hi = 0; seen = 0; err_seen = 0; rd_seen = 32'hFFFFFFFF;
        for (int c = 0; c < 100 && !seen; c++) begin
            mid();
            if (bus_req) hi++;
            if (d_valid) begin
                seen = 1; rd_seen = d_rd; err_seen = bus_err;
            end
            if (!seen) tick();
        end
        chk("to_valid_seen", seen, 1);
        chk("to_req_cycles", hi, TIMEOUT);
        chk("to_rd_zero", rd_seen, 0);
        chk("to_err_set", err_seen, 1);
        tick(); d_req = 0;
        tick();
        mid();
        chk("to_err_sticky", bus_err, 1);

        // Asynchronous reset in D_BUSY
        tick(); d_req = 1; d_adrs = 32'h90;
        tick();
        mid();
        chk("rm_busy", bus_req, 1);
        #2; reset = 1; d_req = 0;
        #1;
        chk("rm_bus_cleared", {bus_req, bus_err, bus_adrs}, 0);
        chk("rm_rd_cleared", {i_rd, d_rd}, 0);
        tick(); tick(); reset = 0;
        any_valid = 0;
        for (int c = 0; c < 3; c++) begin
            mid();
            any_valid = any_valid | d_valid | i_valid;
            tick();
        end
        chk("rm_no_valid", any_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
